cache_ctrl_nway: RTL and testbench
==================================

Name: cache_ctrl_nway

Overview:
- Next-generation cache controller FSM that sits between the CPU request port and the AXI-4 memory master.
- Generalises the single-way design: N-way set associativity with victim selection, a parametrised burst length, and a selectable write-back or write-through policy.
- Uses full AXI-style channel handshakes (AW/W/B/AR/R) and a line-beat counter.
- Drives the tag/data/dirty/LRU array enables. Arrays and datapath live outside this block.

Parameters:
- WAYS, 4: associativity (power of 2, ≥2).
- BEATS, 16: memory beats per cache line (power of 2, ≥2).
- WRITE_BACK, 1: 1 = write-back/write-allocate; 0 = write-through/no-write-allocate.
- WAY_W, $clog2(WAYS): way index width.
- BEAT_W, $clog2(BEATS): beat index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_valid  in  1  CPU request valid; held stable until served
- cpu_rw  in  1  1 = write, 0 = read
- cpu_ready  out  1  controller can evaluate a lookup this cycle
- hit  out  1  lookup hit, pulsed with acceptance
- resp_valid  out  1  request complete (read data valid / write done)
- way_match  in  WAYS  per-way tag match and valid for the current index
- way_valid  in  WAYS  per-way valid bits
- way_dirty  in  WAYS  per-way dirty bits
- lru_way  in  WAY_W  LRU way from the replacement array
- sel_way  out  WAY_W  way addressed by array enables
- data_we  out  1  CPU word write into sel_way
- fill_we  out  1  write R beat into sel_way at beat_idx
- tag_we  out  1  write tag and set valid for sel_way
- dirty_set  out  1  set dirty of sel_way
- dirty_clr  out  1  clear dirty of sel_way
- lru_touch  out  1  mark sel_way most-recently-used
- beat_idx  out  BEAT_W  current burst beat
- addr_sel  out  2  memory address source: 00 CPU word, 01 victim line, 10 fill line
- aw_valid  out  1  write-address valid
- aw_ready  in  1  write-address ready
- w_valid  out  1  write-data valid
- w_ready  in  1  write-data ready
- w_last  out  1  final write beat
- b_valid  in  1  write-response valid
- b_ready  out  1  write-response ready
- ar_valid  out  1  read-address valid
- ar_ready  in  1  read-address ready
- r_valid  in  1  read-data valid
- r_last  in  1  final read beat
- r_ready  out  1  read-data ready
- proto_err  out  1  sticky: r_last did not coincide with beat BEATS-1

Behaviour:
- Reset (rst=1 at posedge, any state): state IDLE, beat counter 0, victim register 0, proto_err 0. Every output is 0 in IDLE except cpu_ready=1. A burst in flight is abandoned; memory-side cleanup is the interconnect's responsibility.
- All outputs are Moore/Mealy combinational from state plus inputs. Array enables are single-cycle pulses. sel_way is the victim register in every state other than IDLE.
- IDLE, lookup on cpu_valid (cpu_ready=1):
  - Hit: way_match≠0. Matched way = lowest set bit; sel_way = that way.
  - Read hit: hit=1, resp_valid=1, lru_touch=1, same cycle; stay IDLE.
  - Write hit, WRITE_BACK=1: hit=1, data_we=1, dirty_set=1, lru_touch=1, resp_valid=1; stay IDLE.
  - Write hit, WRITE_BACK=0: hit=1, data_we=1, lru_touch=1, latch way; go WT_AW.
  - Miss, victim choice: lowest-index way with way_valid=0; if all ways are valid, lru_way. The victim is latched.
  - Miss, dirty victim: WRITE_BACK=1 and victim valid and dirty → WB_AW.
  - Miss, write with WRITE_BACK=0 → WT_AW (no allocate).
  - Miss, otherwise → LD_AR.
  - After any miss the FSM returns to IDLE. The held CPU request re-evaluates and hits, so a miss costs one extra lookup cycle.
- WB_AW: aw_valid=1, addr_sel=01. On aw_ready → WB_W, counter=0.
- WB_W:
  - w_valid=1, addr_sel=01, beat_idx=counter, w_last=(counter==BEATS-1).
  - Counter increments only on w_valid&&w_ready.
  - Last beat accepted → WB_B.
- WB_B: b_ready=1. On b_valid: dirty_clr=1 → LD_AR.
- LD_AR: ar_valid=1, addr_sel=10. On ar_ready → LD_R, counter=0.
- LD_R:
  - r_ready=1. Each r_valid pulses fill_we with beat_idx=counter, then counter++.
  - On the beat with counter==BEATS-1: also tag_we=1, dirty_clr=1, lru_touch=1; → IDLE, counter=0.
  - r_last on any other beat, or absent on the last beat: set proto_err. Beat counting alone still terminates the burst.
- WT_AW: aw_valid=1, addr_sel=00. On aw_ready → WT_W.
- WT_W: w_valid=1, w_last=1, beat_idx=0. On w_ready → WT_B.
- WT_B: b_ready=1. On b_valid: resp_valid=1 → IDLE.
- Handshake rules:
  - Once asserted, a valid stays high until the corresponding ready.
  - cpu_ready=0 outside IDLE.
  - Simultaneous valid and ready completes the transfer that cycle.
- Counter width is BEAT_W+1. It never exceeds BEATS-1 while in WB_W or LD_R.
- States with no handshake progress hold indefinitely; the block has no timeout.

Test Plan:
- Read hit: rst, then cpu_valid=1, rw=0, way_match=4'b0100 → same cycle hit=1, resp_valid=1, sel_way=2, lru_touch=1; state stays IDLE.
- Clean miss, WAYS=4, BEATS=16: way_valid=4'b1111, way_dirty=0, lru_way=3 → ar_valid with addr_sel=10; then 16 r_valid beats, r_last on 16th → 16 fill_we pulses, beat_idx 0..15, sel_way=3, tag_we on beat 15; next cycle the lookup hits.
- Dirty eviction: victim way 1 dirty → AW, then 16 W beats with w_last only on beat 15 (w_ready toggled 1/0 each cycle, 31 cycles total); b_valid → dirty_clr; then AR fill.
- Invalid-way preference: way_valid=4'b1011, lru_way=0 → sel_way=2, no write-back.
- WRITE_BACK=0 write hit → data_we pulse, single AW/W beat (w_last=1), resp_valid only on b_valid, cpu_ready=0 meanwhile; write miss → same path, no ar_valid.
- Error and reset: r_last early on beat 7 → proto_err=1 sticky, fill completes at beat 15. Reset asserted in WB_W beat 5 → next cycle IDLE, all outputs 0 except cpu_ready, proto_err=0.

Source files
------------

// File: rtl/cache_ctrl_nway.sv
// Cache controller FSM for an N-way set-associative cache behind an AXI-style memory master.
// Sequences lookups, victim write-back, line fill and write-through stores; arrays live outside.
module cache_ctrl_nway #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned BEATS      = 16,
    parameter bit          WRITE_BACK = 1'b1,
    parameter int unsigned WAY_W      = $clog2(WAYS),
    parameter int unsigned BEAT_W     = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    output logic              cpu_ready,
    output logic              hit,
    output logic              resp_valid,
    input  logic [WAYS-1:0]   way_match,
    input  logic [WAYS-1:0]   way_valid,
    input  logic [WAYS-1:0]   way_dirty,
    input  logic [WAY_W-1:0]  lru_way,
    output logic [WAY_W-1:0]  sel_way,
    output logic              data_we,
    output logic              fill_we,
    output logic              tag_we,
    output logic              dirty_set,
    output logic              dirty_clr,
    output logic              lru_touch,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [1:0]        addr_sel,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              ar_valid,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic              r_last,
    output logic              r_ready,
    output logic              proto_err
);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StWbAw = 4'd1;
    localparam logic [3:0] StWbW  = 4'd2;
    localparam logic [3:0] StWbB  = 4'd3;
    localparam logic [3:0] StLdAr = 4'd4;
    localparam logic [3:0] StLdR  = 4'd5;
    localparam logic [3:0] StWtAw = 4'd6;
    localparam logic [3:0] StWtW  = 4'd7;
    localparam logic [3:0] StWtB  = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [BEAT_W:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             proto_err_q, proto_err_d;

    logic [WAY_W-1:0] hit_way, miss_way;
    logic             any_hit, victim_dirty, last_beat;
    logic [BEAT_W:0]  cnt_inc;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit_way  = '0;
        miss_way = lru_way;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (way_match[i]) hit_way = WAY_W'(i);
            if (!way_valid[i]) miss_way = WAY_W'(i);
        end
    end

    assign any_hit      = |way_match;
    assign victim_dirty = way_valid[miss_way] & way_dirty[miss_way];
    assign last_beat    = (cnt_q == (BEAT_W+1)'(BEATS - 1));
    assign cnt_inc      = cnt_q + (BEAT_W+1)'(1);
    assign proto_err    = proto_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        proto_err_d = proto_err_q;
        cpu_ready   = 1'b0;
        hit         = 1'b0;
        resp_valid  = 1'b0;
        sel_way     = victim_q;
        data_we     = 1'b0;
        fill_we     = 1'b0;
        tag_we      = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        lru_touch   = 1'b0;
        beat_idx    = '0;
        addr_sel    = 2'b00;
        aw_valid    = 1'b0;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        b_ready     = 1'b0;
        ar_valid    = 1'b0;
        r_ready     = 1'b0;

        case (state_q)
            StIdle: begin
                cpu_ready = 1'b1;
                sel_way   = '0;
                if (cpu_valid) begin
                    if (any_hit) begin
                        hit       = 1'b1;
                        sel_way   = hit_way;
                        lru_touch = 1'b1;
                        if (!cpu_rw) begin
                            resp_valid = 1'b1;
                        end else if (WRITE_BACK) begin
                            data_we    = 1'b1;
                            dirty_set  = 1'b1;
                            resp_valid = 1'b1;
                        end else begin
                            data_we  = 1'b1;
                            victim_d = hit_way;
                            state_d  = StWtAw;
                        end
                    end else begin
                        sel_way  = miss_way;
                        victim_d = miss_way;
                        if (WRITE_BACK && victim_dirty) state_d = StWbAw;
                        else if (!WRITE_BACK && cpu_rw) state_d = StWtAw;
                        else                            state_d = StLdAr;
                    end
                end
            end
            StWbAw: begin
                aw_valid = 1'b1;
                addr_sel = 2'b01;
                if (aw_ready) begin
                    state_d = StWbW;
                    cnt_d   = '0;
                end
            end
            StWbW: begin
                w_valid  = 1'b1;
                addr_sel = 2'b01;
                beat_idx = cnt_q[BEAT_W-1:0];
                w_last   = last_beat;
                if (w_ready) begin
                    if (last_beat) begin
                        state_d = StWbB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StWbB: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    dirty_clr = 1'b1;
                    state_d   = StLdAr;
                end
            end
            StLdAr: begin
                ar_valid = 1'b1;
                addr_sel = 2'b10;
                if (ar_ready) begin
                    state_d = StLdR;
                    cnt_d   = '0;
                end
            end
            StLdR: begin
                r_ready  = 1'b1;
                beat_idx = cnt_q[BEAT_W-1:0];
                if (r_valid) begin
                    fill_we = 1'b1;
                    // Beat count ends the burst; a misplaced r_last is only flagged.
                    if (r_last != last_beat) proto_err_d = 1'b1;
                    if (last_beat) begin
                        tag_we    = 1'b1;
                        dirty_clr = 1'b1;
                        lru_touch = 1'b1;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StWtAw: begin
                aw_valid = 1'b1;
                if (aw_ready) state_d = StWtW;
            end
            StWtW: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                if (w_ready) state_d = StWtB;
            end
            StWtB: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    resp_valid = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            victim_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            victim_q    <= victim_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: write-back and write-through instances share stimulus and are
// checked by a table, directed sequences and a plan-queue reference model under random inputs.
module tb_cache_ctrl_nway;

    localparam int WAYS  = 4;
    localparam int BEATS = 16;
    localparam int KAw = 0, KW = 1, KB = 2, KAr = 3, KR = 4;
    localparam int NIdle = 0, NAw = 1, NAr = 2;

    typedef struct packed {
        logic       cpu_ready, hit, resp_valid;
        logic [1:0] sel_way;
        logic       data_we, fill_we, tag_we, dirty_set, dirty_clr, lru_touch;
        logic [3:0] beat_idx;
        logic [1:0] addr_sel;
        logic       aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, proto_err;
    } out_t;

    typedef struct {
        int         kind;
        int         beat;
        logic [1:0] src;
        bit         last;
        bit         wt;
    } step_t;

    typedef struct {
        bit         rw;
        logic [3:0] match, valid, dirty;
        logic [1:0] lru, sel;
        bit         hit, resp_wb, resp_wt;
        int         nxt_wb, nxt_wt;
    } vec_t;

    logic clk, rst, cpu_valid, cpu_rw;
    logic [3:0] way_match, way_valid, way_dirty;
    logic [1:0] lru_way;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;

    logic cpu_ready_w, hit_w, resp_valid_w, data_we_w, fill_we_w, tag_we_w, dirty_set_w;
    logic dirty_clr_w, lru_touch_w, aw_valid_w, w_valid_w, w_last_w, b_ready_w, ar_valid_w;
    logic r_ready_w, proto_err_w;
    logic [1:0] sel_way_w, addr_sel_w;
    logic [3:0] beat_idx_w;
    logic cpu_ready_t, hit_t, resp_valid_t, data_we_t, fill_we_t, tag_we_t, dirty_set_t;
    logic dirty_clr_t, lru_touch_t, aw_valid_t, w_valid_t, w_last_t, b_ready_t, ar_valid_t;
    logic r_ready_t, proto_err_t;
    logic [1:0] sel_way_t, addr_sel_t;
    logic [3:0] beat_idx_t;

    out_t ow, ot;
    assign ow = {cpu_ready_w, hit_w, resp_valid_w, sel_way_w, data_we_w, fill_we_w, tag_we_w,
                 dirty_set_w, dirty_clr_w, lru_touch_w, beat_idx_w, addr_sel_w, aw_valid_w,
                 w_valid_w, w_last_w, b_ready_w, ar_valid_w, r_ready_w, proto_err_w};
    assign ot = {cpu_ready_t, hit_t, resp_valid_t, sel_way_t, data_we_t, fill_we_t, tag_we_t,
                 dirty_set_t, dirty_clr_t, lru_touch_t, beat_idx_t, addr_sel_t, aw_valid_t,
                 w_valid_t, w_last_t, b_ready_t, ar_valid_t, r_ready_t, proto_err_t};

    cache_ctrl_nway #(.WAYS(WAYS), .BEATS(BEATS), .WRITE_BACK(1'b1)) dut_wb (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw),
        .cpu_ready(cpu_ready_w), .hit(hit_w), .resp_valid(resp_valid_w),
        .way_match(way_match), .way_valid(way_valid), .way_dirty(way_dirty), .lru_way(lru_way),
        .sel_way(sel_way_w), .data_we(data_we_w), .fill_we(fill_we_w), .tag_we(tag_we_w),
        .dirty_set(dirty_set_w), .dirty_clr(dirty_clr_w), .lru_touch(lru_touch_w),
        .beat_idx(beat_idx_w), .addr_sel(addr_sel_w), .aw_valid(aw_valid_w),
        .aw_ready(aw_ready), .w_valid(w_valid_w), .w_ready(w_ready), .w_last(w_last_w),
        .b_valid(b_valid), .b_ready(b_ready_w), .ar_valid(ar_valid_w), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready_w), .proto_err(proto_err_w)
    );

    cache_ctrl_nway #(.WAYS(WAYS), .BEATS(BEATS), .WRITE_BACK(1'b0)) dut_wt (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw),
        .cpu_ready(cpu_ready_t), .hit(hit_t), .resp_valid(resp_valid_t),
        .way_match(way_match), .way_valid(way_valid), .way_dirty(way_dirty), .lru_way(lru_way),
        .sel_way(sel_way_t), .data_we(data_we_t), .fill_we(fill_we_t), .tag_we(tag_we_t),
        .dirty_set(dirty_set_t), .dirty_clr(dirty_clr_t), .lru_touch(lru_touch_t),
        .beat_idx(beat_idx_t), .addr_sel(addr_sel_t), .aw_valid(aw_valid_t),
        .aw_ready(aw_ready), .w_valid(w_valid_t), .w_ready(w_ready), .w_last(w_last_t),
        .b_valid(b_valid), .b_ready(b_ready_t), .ar_valid(ar_valid_t), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready_t), .proto_err(proto_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    // Reference model: each instance holds a list of pending channel steps; idle when empty.
    step_t      plan [2][40];
    int         len [2];
    int         pos [2];
    logic [1:0] victim [2];
    bit         perr [2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] low_way(logic [3:0] m);
        for (int i = 0; i < WAYS; i++) if (m[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [1:0] pick_victim();
        for (int i = 0; i < WAYS; i++) if (!way_valid[i]) return 2'(i);
        return lru_way;
    endfunction

    task automatic push(int k, int kind, int beat, logic [1:0] src, bit last, bit wt);
        plan[k][len[k]] = '{kind, beat, src, last, wt};
        len[k]++;
    endtask

    task automatic plan_fill(int k);
        push(k, KAr, 0, 2'b10, 1'b0, 1'b0);
        for (int b = 0; b < BEATS; b++) push(k, KR, b, 2'b00, b == BEATS - 1, 1'b0);
    endtask

    task automatic plan_wb(int k);
        push(k, KAw, 0, 2'b01, 1'b0, 1'b0);
        for (int b = 0; b < BEATS; b++) push(k, KW, b, 2'b01, b == BEATS - 1, 1'b0);
        push(k, KB, 0, 2'b00, 1'b0, 1'b0);
        plan_fill(k);
    endtask

    task automatic plan_wt(int k);
        push(k, KAw, 0, 2'b00, 1'b0, 1'b1);
        push(k, KW, 0, 2'b00, 1'b1, 1'b1);
        push(k, KB, 0, 2'b00, 1'b0, 1'b1);
    endtask

    function automatic out_t model_out(int k);
        out_t  o = '0;
        step_t s;
        o.proto_err = perr[k];
        if (pos[k] >= len[k]) begin
            o.cpu_ready = 1'b1;
            if (cpu_valid) begin
                if (way_match != 4'b0) begin
                    o.hit       = 1'b1;
                    o.sel_way   = low_way(way_match);
                    o.lru_touch = 1'b1;
                    if (!cpu_rw) o.resp_valid = 1'b1;
                    else begin
                        o.data_we = 1'b1;
                        if (k == 0) begin
                            o.dirty_set  = 1'b1;
                            o.resp_valid = 1'b1;
                        end
                    end
                end else begin
                    o.sel_way = pick_victim();
                end
            end
        end else begin
            s = plan[k][pos[k]];
            o.sel_way = victim[k];
            case (s.kind)
                KAw: begin o.aw_valid = 1'b1; o.addr_sel = s.src; end
                KW: begin
                    o.w_valid  = 1'b1;
                    o.addr_sel = s.src;
                    o.beat_idx = 4'(s.beat);
                    o.w_last   = s.last;
                end
                KB: begin
                    o.b_ready = 1'b1;
                    if (b_valid) begin
                        if (s.wt) o.resp_valid = 1'b1;
                        else      o.dirty_clr  = 1'b1;
                    end
                end
                KAr: begin o.ar_valid = 1'b1; o.addr_sel = s.src; end
                default: begin
                    o.r_ready  = 1'b1;
                    o.beat_idx = 4'(s.beat);
                    if (r_valid) begin
                        o.fill_we = 1'b1;
                        if (s.last) begin
                            o.tag_we    = 1'b1;
                            o.dirty_clr = 1'b1;
                            o.lru_touch = 1'b1;
                        end
                    end
                end
            endcase
        end
        return o;
    endfunction

    task automatic model_step(int k);
        bit         wb = (k == 0);
        step_t      s;
        bit         fire;
        logic [1:0] v;
        if (rst) begin
            len[k] = 0; pos[k] = 0; victim[k] = 2'd0; perr[k] = 1'b0;
            return;
        end
        if (pos[k] >= len[k]) begin
            if (cpu_valid) begin
                len[k] = 0; pos[k] = 0;
                if (way_match != 4'b0) begin
                    if (cpu_rw && !wb) begin
                        victim[k] = low_way(way_match);
                        plan_wt(k);
                    end
                end else begin
                    v = pick_victim();
                    victim[k] = v;
                    if (wb && way_valid[v] && way_dirty[v]) plan_wb(k);
                    else if (cpu_rw && !wb)                 plan_wt(k);
                    else                                    plan_fill(k);
                end
            end
        end else begin
            s = plan[k][pos[k]];
            case (s.kind)
                KAw:     fire = aw_ready;
                KW:      fire = w_ready;
                KB:      fire = b_valid;
                KAr:     fire = ar_ready;
                default: fire = r_valid;
            endcase
            if (s.kind == KR && r_valid && (r_last != s.last)) perr[k] = 1'b1;
            if (fire) pos[k]++;
        end
    endtask

    task automatic settle();
        out_t e0, e1;
        @(negedge clk);
        if (model_on) begin
            e0 = model_out(0);
            e1 = model_out(1);
            check("model_wb", ow, e0);
            check("model_wt", ot, e1);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_rw = 0; way_match = 0; way_valid = 0; way_dirty = 0; lru_way = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0; r_last = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int nxt_code(out_t o);
        if (o.aw_valid) return NAw;
        if (o.ar_valid) return NAr;
        if (o.cpu_ready) return NIdle;
        return 9;
    endfunction

    function automatic logic [1:0] nxt_sel(int n, int k);
        if (n == NAw) return (k == 0) ? 2'b01 : 2'b00;
        if (n == NAr) return 2'b10;
        return 2'b00;
    endfunction

    vec_t vecs [11];
    out_t idle_o;
    int   fills, beat, cyc;

    initial begin
        vecs[0]  = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 2'd2, 1, 1, 1, NIdle, NIdle};
        vecs[1]  = '{1'b0, 4'b0110, 4'b1111, 4'b0000, 2'd0, 2'd1, 1, 1, 1, NIdle, NIdle};
        vecs[2]  = '{1'b1, 4'b1000, 4'b1111, 4'b1111, 2'd0, 2'd3, 1, 1, 0, NIdle, NAw};
        vecs[3]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 2'd3, 0, 0, 0, NAr, NAr};
        vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 2'd1, 0, 0, 0, NAw, NAr};
        vecs[5]  = '{1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 2'd2, 0, 0, 0, NAr, NAr};
        vecs[6]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 2'd0, 0, 0, 0, NAr, NAw};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd3, 2'd0, 0, 0, 0, NAr, NAw};
        vecs[8]  = '{1'b0, 4'b0000, 4'b1110, 4'b0001, 2'd2, 2'd0, 0, 0, 0, NAr, NAr};
        vecs[9]  = '{1'b1, 4'b0000, 4'b1111, 4'b1000, 2'd3, 2'd3, 0, 0, 0, NAw, NAw};
        vecs[10] = '{1'b1, 4'b0011, 4'b1111, 4'b0000, 2'd0, 2'd0, 1, 1, 0, NIdle, NAw};
        idle_o = '0;
        idle_o.cpu_ready = 1'b1;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_on = 1'b1;
        settle();
        check("reset_out_wb", ow, idle_o);
        check("reset_out_wt", ot, idle_o);
        advance();

        // Single lookups from reset: same-cycle response and the state entered next.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            cpu_valid = 1'b1; cpu_rw = vecs[i].rw; way_match = vecs[i].match;
            way_valid = vecs[i].valid; way_dirty = vecs[i].dirty; lru_way = vecs[i].lru;
            settle();
            check("vec_sel_wb", ow.sel_way, vecs[i].sel);
            check("vec_sel_wt", ot.sel_way, vecs[i].sel);
            check("vec_hit_wb", ow.hit, vecs[i].hit);
            check("vec_resp_wb", ow.resp_valid, vecs[i].resp_wb);
            check("vec_resp_wt", ot.resp_valid, vecs[i].resp_wt);
            advance();
            cpu_valid = 1'b0;
            settle();
            check("vec_next_wb", nxt_code(ow), vecs[i].nxt_wb);
            check("vec_next_wt", nxt_code(ot), vecs[i].nxt_wt);
            check("vec_asel_wb", ow.addr_sel, nxt_sel(vecs[i].nxt_wb, 0));
            check("vec_asel_wt", ot.addr_sel, nxt_sel(vecs[i].nxt_wt, 1));
            advance();
        end

        // Clean miss, 16-beat fill into LRU way 3, then the held request hits.
        do_reset();
        cpu_valid = 1'b1; way_valid = 4'hf; lru_way = 2'd3;
        settle();
        check("miss_hit", ow.hit, 0);
        advance();
        settle();
        check("fill_ar_valid", ow.ar_valid, 1);
        check("fill_ar_asel", ow.addr_sel, 2'b10);
        advance();
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        fills = 0;
        for (int b = 0; b < BEATS; b++) begin
            r_valid = 1'b1; r_last = (b == BEATS - 1);
            settle();
            check("fill_beat_idx", ow.beat_idx, b);
            check("fill_sel_way", ow.sel_way, 3);
            check("fill_tag_we", ow.tag_we, b == BEATS - 1);
            fills += int'(ow.fill_we);
            advance();
        end
        r_valid = 1'b0; r_last = 1'b0;
        check("fill_count", fills, BEATS);
        way_match = 4'b1000;
        settle();
        check("refill_hit", ow.hit, 1);
        check("refill_resp", ow.resp_valid, 1);
        check("refill_perr", ow.proto_err, 0);
        advance();

        // Dirty victim way 1: write-back with w_ready alternating 1/0.
        do_reset();
        cpu_valid = 1'b1; way_valid = 4'hf; way_dirty = 4'b0010; lru_way = 2'd1;
        settle();
        check("wb_sel_way", ow.sel_way, 1);
        advance();
        cpu_valid = 1'b0; aw_ready = 1'b1;
        settle();
        check("wb_aw_valid", ow.aw_valid, 1);
        check("wb_aw_asel", ow.addr_sel, 2'b01);
        advance();
        aw_ready = 1'b0;
        beat = 0; cyc = 0;
        while (beat < BEATS && cyc < 100) begin
            w_ready = (cyc % 2 == 0);
            settle();
            check("wb_w_valid", ow.w_valid, 1);
            if (w_ready) begin
                check("wb_beat_idx", ow.beat_idx, beat);
                check("wb_w_last", ow.w_last, beat == BEATS - 1);
                beat++;
            end
            advance();
            cyc++;
        end
        w_ready = 1'b0;
        check("wb_cycles", cyc, 2 * BEATS - 1);
        settle();
        check("wb_b_ready", ow.b_ready, 1);
        check("wb_no_clr", ow.dirty_clr, 0);
        advance();
        b_valid = 1'b1;
        settle();
        check("wb_dirty_clr", ow.dirty_clr, 1);
        advance();
        b_valid = 1'b0;
        settle();
        check("wb_then_ar", ow.ar_valid, 1);
        advance();

        // r_last on beat 7 instead of 15: sticky error, fill still runs 16 beats.
        do_reset();
        cpu_valid = 1'b1; way_valid = 4'hf; lru_way = 2'd0;
        tick();
        cpu_valid = 1'b0; ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        fills = 0;
        for (int b = 0; b < BEATS; b++) begin
            r_valid = 1'b1; r_last = (b == 7);
            settle();
            check("perr_during", ow.proto_err, b >= 8);
            fills += int'(ow.fill_we);
            advance();
        end
        r_valid = 1'b0; r_last = 1'b0;
        check("perr_fill_count", fills, BEATS);
        tick();
        settle();
        check("perr_sticky", ow.proto_err, 1);
        check("perr_idle", ow.cpu_ready, 1);
        advance();

        // Reset while on write-back beat 5 (proto_err still set from above).
        cpu_valid = 1'b1; way_valid = 4'hf; way_dirty = 4'b0100; lru_way = 2'd2;
        tick();
        cpu_valid = 1'b0; aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b1;
        for (int b = 0; b < 5; b++) tick();
        w_ready = 1'b0;
        settle();
        check("rst_mid_beat", ow.beat_idx, 5);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        settle();
        check("rst_mid_out_wb", ow, idle_o);
        check("rst_mid_out_wt", ot, idle_o);
        advance();

        // Write-through store: hit then miss, single beat, response only on B.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            cpu_valid = 1'b1; cpu_rw = 1'b1; way_valid = 4'hf; lru_way = 2'd2;
            way_match = (m == 0) ? 4'b0001 : 4'b0000;
            settle();
            check("wt_data_we", ot.data_we, m == 0);
            check("wt_resp_early", ot.resp_valid, 0);
            advance();
            settle();
            check("wt_aw_valid", ot.aw_valid, 1);
            check("wt_aw_asel", ot.addr_sel, 2'b00);
            check("wt_busy", ot.cpu_ready, 0);
            advance();
            aw_ready = 1'b1;
            tick();
            aw_ready = 1'b0;
            settle();
            check("wt_w_valid", ot.w_valid, 1);
            check("wt_w_last", ot.w_last, 1);
            check("wt_sel_way", ot.sel_way, (m == 0) ? 0 : 2);
            check("wt_no_ar", ot.ar_valid, 0);
            advance();
            w_ready = 1'b1;
            tick();
            w_ready = 1'b0;
            settle();
            check("wt_b_ready", ot.b_ready, 1);
            check("wt_b_wait", ot.resp_valid, 0);
            advance();
            b_valid = 1'b1;
            settle();
            check("wt_resp", ot.resp_valid, 1);
            advance();
            b_valid = 1'b0; cpu_valid = 1'b0;
            settle();
            check("wt_done_idle", ot.cpu_ready, 1);
            advance();
        end

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cpu_valid = ($urandom_range(0, 3) != 0);
            cpu_rw    = 1'($urandom);
            way_match = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
            way_valid = 4'($urandom);
            way_dirty = 4'($urandom);
            lru_way   = 2'($urandom);
            aw_ready  = ($urandom_range(0, 3) != 0);
            w_ready   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            ar_ready  = ($urandom_range(0, 3) != 0);
            r_valid   = ($urandom_range(0, 3) != 0);
            r_last    = ($urandom_range(0, 11) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
